// File: rtl/led_centroid_reader_pkg.sv
// led_centroid_reader_pkg: shared calibration types for the reader, calibration FSM and accumulation RAM
package led_centroid_reader_pkg;
  typedef enum logic {READ, WRITE} accum_request_t;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DIVIDE, DONE} reader_state_t;
endpackage

// File: rtl/led_centroid_reader_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle
// Ports: clk_pixel/rst; start_i loads dividend_i/divisor_i; done_o pulses
// NW cycles later with quotient_o holding the low QW bits of the quotient.
module seq_divider #(
  parameter int NW = 19,
  parameter int DW = 12,
  parameter int QW = 7
) (
  input  logic          clk_pixel,
  input  logic          rst,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          done_o,
  output logic [QW-1:0] quotient_o
);
  localparam int KW = $clog2(NW + 1);
  logic [DW-1:0] rem_q, div_q, diff;
  logic [NW-1:0] quo_q;
  logic [KW-1:0] cnt_q;
  logic          busy_q, done_q, ge;
  logic [DW:0]   shifted;
  assign shifted    = {rem_q, quo_q[NW-1]};
  assign ge         = shifted >= {1'b0, div_q};
  // When ge holds the true difference is below the divisor, so DW bits suffice.
  assign diff       = shifted[DW-1:0] - div_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q[QW-1:0];
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= '0;
        quo_q  <= dividend_i;
        div_q  <= divisor_i;
        cnt_q  <= KW'(NW);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= ge ? diff : shifted[DW-1:0];
        quo_q <= {quo_q[NW-2:0], ge};
        cnt_q <= cnt_q - KW'(1);
        if (cnt_q == KW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/led_centroid_reader.sv
// led_centroid_reader: scans the accumulation RAM and reports the centroid of cells holding target_id
// Ports: start/target_id begin a scan; ram_* is the read-request/result RAM port
// (requests gated by ram_ready, results in order with address tags);
// busy/done/found/x_out/y_out/count_out report the result.
module led_centroid_reader
  import led_centroid_reader_pkg::*;
#(
  parameter  int LED_ADDRESS_WIDTH = 10,
  parameter  int H_CELLS = 80,
  parameter  int V_CELLS = 45,
  localparam int DEPTH = H_CELLS * V_CELLS,
  localparam int AW = $clog2(DEPTH),
  localparam int XW = $clog2(H_CELLS),
  localparam int YW = $clog2(V_CELLS),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                         clk_pixel,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LED_ADDRESS_WIDTH-1:0] target_id,
  input  logic                         ram_ready,
  output logic [AW-1:0]                ram_addr_out,
  output logic                         ram_request_valid_out,
  input  logic [LED_ADDRESS_WIDTH-1:0] ram_read_in,
  input  logic [AW-1:0]                ram_addr_in,
  input  logic                         ram_result_valid_in,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [XW-1:0]                x_out,
  output logic [YW-1:0]                y_out,
  output logic [CW-1:0]                count_out
);
  reader_state_t                state_q, state_d;
  logic [LED_ADDRESS_WIDTH-1:0] target_q;
  logic [AW-1:0]                scan_q;
  logic [CW-1:0]                rcv_q, count_q;
  logic [XW-1:0]                col_q, qx_q, div_q;
  logic [YW-1:0]                row_q;
  logic [XW+CW-1:0]             sum_x_q;
  logic [YW+CW-1:0]             sum_y_q;
  logic                         phase_q, div_busy_q, take, hit, div_start, div_done;
  assign ram_request_valid_out = state_q == SCAN && ram_ready;
  assign ram_addr_out          = scan_q;
  // A result is consumed only when its tag is the next expected cell, so the
  // column/row pair always describes the returned address and stale words are dropped.
  assign take      = state_q != IDLE && ram_result_valid_in && CW'(ram_addr_in) == rcv_q;
  assign hit       = take && ram_read_in == target_q;
  assign div_start = state_q == DIVIDE && !div_busy_q && count_q != '0;
  assign busy      = state_q inside {SCAN, DRAIN, DIVIDE};
  assign done      = state_q == DONE;
  seq_divider #(.NW(XW + CW), .DW(CW), .QW(XW)) u_div (
    .clk_pixel (clk_pixel),
    .rst       (rst),
    .start_i   (div_start),
    .dividend_i(phase_q ? (XW + CW)'(sum_y_q) : sum_x_q),
    .divisor_i (count_q),
    .done_o    (div_done),
    .quotient_o(div_q)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? SCAN : IDLE;
      SCAN:    state_d = ram_request_valid_out && scan_q == AW'(DEPTH - 1) ? DRAIN : SCAN;
      DRAIN:   state_d = rcv_q == CW'(DEPTH) ? DIVIDE : DRAIN;
      DIVIDE:  state_d = count_q == '0 || (div_done && phase_q) ? DONE : DIVIDE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      scan_q     <= '0;
      rcv_q      <= '0;
      count_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      qx_q       <= '0;
      phase_q    <= 1'b0;
      div_busy_q <= 1'b0;
      found      <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      count_out  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        target_q   <= target_id;
        scan_q     <= '0;
        rcv_q      <= '0;
        count_q    <= '0;
        col_q      <= '0;
        row_q      <= '0;
        sum_x_q    <= '0;
        sum_y_q    <= '0;
        phase_q    <= 1'b0;
        div_busy_q <= 1'b0;
      end
      if (ram_request_valid_out) scan_q <= scan_q + AW'(1);
      if (take) begin
        rcv_q <= rcv_q + CW'(1);
        col_q <= col_q == XW'(H_CELLS - 1) ? '0 : col_q + XW'(1);
        row_q <= col_q == XW'(H_CELLS - 1) ? row_q + YW'(1) : row_q;
      end
      if (hit) begin
        sum_x_q <= sum_x_q + (XW + CW)'(col_q);
        sum_y_q <= sum_y_q + (YW + CW)'(row_q);
        count_q <= count_q + CW'(1);
      end
      if (div_start) div_busy_q <= 1'b1;
      if (div_done) begin
        div_busy_q <= 1'b0;
        phase_q    <= 1'b1;
        qx_q       <= phase_q ? qx_q : div_q;
      end
      if (state_q == DIVIDE && state_d == DONE) begin
        found     <= count_q != '0;
        count_out <= count_q;
        x_out     <= count_q == '0 ? '0 : qx_q;
        y_out     <= count_q == '0 ? '0 : div_q[YW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_led_centroid_reader.sv
// tb_led_centroid_reader: scoreboard bench with a latency-2 RAM model for led_centroid_reader
module tb_led_centroid_reader;
  typedef struct {
    logic       found;
    logic [6:0] x;
    logic [5:0] y;
    logic [11:0] cnt;
  } exp_t;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  target_id = '0;
  logic        ram_ready = 1'b1;
  logic [11:0] ram_addr_out;
  logic        ram_request_valid_out;
  logic [9:0]  ram_read_in;
  logic [11:0] ram_addr_in;
  logic        ram_result_valid_in;
  logic        busy, done, found;
  logic [6:0]  x_out;
  logic [5:0]  y_out;
  logic [11:0] count_out;

  logic [9:0]  mem [0:3599];
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [11:0] a1 = '0, a2 = '0;
  bit          tog = 1'b0;
  bit          seen [4096];
  exp_t        sb [$];
  exp_t        mon_e;
  int          vectors = 0, miscompares = 0;
  int          done_cnt = 0, req_cnt = 0, dup_cnt = 0, oob_cnt = 0;

  led_centroid_reader dut (
    .clk_pixel            (clk_pixel),
    .rst                  (rst),
    .start                (start),
    .target_id            (target_id),
    .ram_ready            (ram_ready),
    .ram_addr_out         (ram_addr_out),
    .ram_request_valid_out(ram_request_valid_out),
    .ram_read_in          (ram_read_in),
    .ram_addr_in          (ram_addr_in),
    .ram_result_valid_in  (ram_result_valid_in),
    .busy                 (busy),
    .done                 (done),
    .found                (found),
    .x_out                (x_out),
    .y_out                (y_out),
    .count_out            (count_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  always @(posedge clk_pixel) begin
    v1 <= ram_request_valid_out;
    a1 <= ram_addr_out;
    v2 <= v1;
    a2 <= a1;
  end
  assign ram_result_valid_in = v2;
  assign ram_addr_in         = a2;
  assign ram_read_in         = (v2 && a2 < 12'd3600) ? mem[a2] : '0;

  always @(negedge clk_pixel) ram_ready = tog ? ~ram_ready : 1'b1;

  always @(negedge clk_pixel) begin
    if (ram_request_valid_out) begin
      req_cnt++;
      if (ram_addr_out >= 12'd3600) oob_cnt++;
      else begin
        if (seen[ram_addr_out]) dup_cnt++;
        seen[ram_addr_out] = 1'b1;
      end
    end
    if (done) begin
      done_cnt++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done with found=%0b x=%0d y=%0d count=%0d, expected no done", found, x_out, y_out, count_out);
      end else begin
        mon_e = sb.pop_front();
        if ({found, x_out, y_out, count_out} !== {mon_e.found, mon_e.x, mon_e.y, mon_e.cnt}) begin
          miscompares++;
          $display("FAIL result: got found=%0b x=%0d y=%0d count=%0d, expected found=%0b x=%0d y=%0d count=%0d",
                   found, x_out, y_out, count_out, mon_e.found, mon_e.x, mon_e.y, mon_e.cnt);
        end
      end
    end
  end

  function automatic exp_t model(input logic [9:0] t);
    exp_t r;
    int sx = 0, sy = 0, n = 0;
    for (int i = 0; i < 3600; i++)
      if (mem[i] == t) begin
        sx += i % 80;
        sy += i / 80;
        n++;
      end
    r.found = n != 0;
    r.x     = n != 0 ? 7'(sx / n) : '0;
    r.y     = n != 0 ? 6'(sy / n) : '0;
    r.cnt   = 12'(n);
    return r;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 3600; i++) mem[i] = '0;
  endtask

  task automatic clear_stats();
    req_cnt = 0;
    dup_cnt = 0;
    oob_cnt = 0;
    done_cnt = 0;
    foreach (seen[i]) seen[i] = 1'b0;
  endtask

  task automatic kick(input logic [9:0] t);
    @(negedge clk_pixel);
    start = 1'b1;
    target_id = t;
    @(negedge clk_pixel);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 20000 && done_cnt == 0; c++) @(negedge clk_pixel);
    if (done_cnt == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done in 20000 cycles, expected done", name);
    end
    repeat (3) @(negedge clk_pixel);
  endtask

  task automatic run(input logic [9:0] t, input string name);
    clear_stats();
    sb.push_back(model(t));
    kick(t);
    wait_done(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_pixel);
    rst = 1'b0;
    @(negedge clk_pixel);
    vectors += 7;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    if (found !== 1'b0) begin miscompares++; $display("FAIL reset_found: got %b expected 0", found); end
    if (x_out !== 7'd0) begin miscompares++; $display("FAIL reset_x: got %0d expected 0", x_out); end
    if (y_out !== 6'd0) begin miscompares++; $display("FAIL reset_y: got %0d expected 0", y_out); end
    if (count_out !== 12'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count_out); end
    if (ram_request_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", ram_request_valid_out); end
  endtask

  task automatic load_basic();
    clear_mem();
    mem[10] = 10'd5;
    mem[11] = 10'd5;
    mem[90] = 10'd5;
    mem[91] = 10'd5;
  endtask

  task automatic test_basic();
    load_basic();
    run(10'd5, "basic");
    vectors += 5;
    if (req_cnt !== 3600) begin miscompares++; $display("FAIL basic_requests: got %0d expected 3600", req_cnt); end
    if (dup_cnt !== 0) begin miscompares++; $display("FAIL basic_dups: got %0d expected 0", dup_cnt); end
    if (oob_cnt !== 0) begin miscompares++; $display("FAIL basic_oob: got %0d expected 0", oob_cnt); end
    if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_absent();
    run(10'd7, "absent");
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL absent_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_ready_toggle();
    load_basic();
    tog = 1'b1;
    run(10'd5, "toggle");
    tog = 1'b0;
    vectors += 4;
    if (req_cnt !== 3600) begin miscompares++; $display("FAIL toggle_requests: got %0d expected 3600", req_cnt); end
    if (dup_cnt !== 0) begin miscompares++; $display("FAIL toggle_dups: got %0d expected 0", dup_cnt); end
    if (oob_cnt !== 0) begin miscompares++; $display("FAIL toggle_oob: got %0d expected 0", oob_cnt); end
    if (done_cnt !== 1) begin miscompares++; $display("FAIL toggle_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_corner();
    clear_mem();
    mem[3599] = 10'd1023;
    run(10'd1023, "corner");
    vectors += 3;
    if (x_out !== 7'd79) begin miscompares++; $display("FAIL corner_x: got %0d expected 79", x_out); end
    if (y_out !== 6'd44) begin miscompares++; $display("FAIL corner_y: got %0d expected 44", y_out); end
    if (count_out !== 12'd1) begin miscompares++; $display("FAIL corner_count: got %0d expected 1", count_out); end
  endtask

  task automatic test_random();
    clear_mem();
    for (int i = 0; i < 300; i++) mem[$urandom_range(3599)] = 10'($urandom_range(50) + 1);
    for (int i = 0; i < 25; i++) mem[$urandom_range(3599)] = 10'd300;
    run(10'd300, "random_a");
    run(10'd17, "random_b");
    vectors++;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL random_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    load_basic();
    clear_stats();
    sb.push_back(model(10'd5));
    kick(10'd5);
    repeat (50) @(negedge clk_pixel);
    kick(10'd7);
    wait_done("busy_start");
    repeat (200) @(negedge clk_pixel);
    vectors += 2;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL busy_start_done_pulses: got %0d expected 1", done_cnt); end
    if (req_cnt !== 3600) begin miscompares++; $display("FAIL busy_start_requests: got %0d expected 3600", req_cnt); end
  endtask

  task automatic test_reset_abort();
    load_basic();
    clear_stats();
    sb.push_back(model(10'd5));
    kick(10'd5);
    repeat (100) @(negedge clk_pixel);
    rst = 1'b1;
    @(negedge clk_pixel);
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (300) @(negedge clk_pixel);
    if (done_cnt !== 0) begin miscompares++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt); end
    sb.delete();
    run(10'd5, "after_abort");
    vectors += 2;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL after_abort_done_pulses: got %0d expected 1", done_cnt); end
    if (req_cnt !== 3600) begin miscompares++; $display("FAIL after_abort_requests: got %0d expected 3600", req_cnt); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic();
    test_absent();
    test_ready_toggle();
    test_corner();
    test_random();
    test_back_to_back();
    test_reset_abort();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expected: got %0d pending results, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
